shift_add_multiplier: RTL and testbench

- Sequential unsigned shift-add multiplier. It is the multiply-side counterpart of the restoring divider datapath and shares its 2W-bit combined register and its step1/step2 controller style.
- Contains its own controller FSM, multiplicand register, combined product/multiplier register and adder.
- Exposes a start/ready handshake to the PA1 top-level test harness.

---
 rtl/mult_pkg.sv | 19 +
 rtl/shift_add_multiplier_if.sv | 21 ++
 rtl/mult_alu.sv | 12 +
 rtl/shift_add_multiplier.sv | 130 +++++++++++++
 tb/tb_shift_add_multiplier.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: default width, FSM encoding and count sizing.
package mult_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADD   = 3'd1,
        SHIFT = 3'd2,
        DONE  = 3'd3,
        FIX   = 3'd4
    } state_e;

    // Width of the step counter for a given operand width (log2(W) bits).
    function automatic int count_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Start/ready handshake and operand/product bus of the shift-add multiplier.
interface shift_add_multiplier_if #(
    parameter int WIDTH = mult_pkg::WIDTH_DEF
);
    logic               start;
    logic [WIDTH-1:0]   Multiplicand_in;
    logic [WIDTH-1:0]   Multiplier_in;
    logic               busy;
    logic               ready;
    logic [2*WIDTH-1:0] Product_out;

    modport master (
        output start, Multiplicand_in, Multiplier_in,
        input  busy, ready, Product_out
    );

    modport slave (
        input  start, Multiplicand_in, Multiplier_in,
        output busy, ready, Product_out
    );
endinterface

// File: rtl/mult_alu.sv
// Combinational W-bit adder returning {carry, sum} for the ADD step.
module mult_alu
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH:0]   sum_o
);
    assign sum_o = {1'b0, a_i} + {1'b0, b_i};
endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier, falling-edge clocked, async active-low reset.
// Define MULT_SIGNED_EN for two's-complement operands (adds a sign fix-up state).
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    shift_add_multiplier_if.slave bus
);
    localparam int                CNT_W = count_w(WIDTH);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic                 carry_q, carry_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 busy_q, busy_d;
    logic                 ready_q, ready_d;
    logic [WIDTH:0]       sum;

`ifdef MULT_SIGNED_EN
    logic                 sign_q, sign_d;

    // Magnitude of a two's-complement value; the most-negative value maps to 2^(W-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction
`endif

    mult_alu #(.WIDTH(WIDTH)) u_alu (
        .a_i   (prod_q[2*WIDTH-1:WIDTH]),
        .b_i   (mcand_q),
        .sum_o (sum)
    );

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        carry_d = carry_q;
        count_d = count_q;
`ifdef MULT_SIGNED_EN
        sign_d  = sign_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
`ifdef MULT_SIGNED_EN
                    mcand_d = magnitude(bus.Multiplicand_in);
                    prod_d  = {{WIDTH{1'b0}}, magnitude(bus.Multiplier_in)};
                    sign_d  = bus.Multiplicand_in[WIDTH-1] ^ bus.Multiplier_in[WIDTH-1];
`else
                    mcand_d = bus.Multiplicand_in;
                    prod_d  = {{WIDTH{1'b0}}, bus.Multiplier_in};
`endif
                    carry_d = 1'b0;
                    count_d = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                if (prod_q[0]) begin
                    {carry_d, prod_d[2*WIDTH-1:WIDTH]} = sum;
                end else begin
                    carry_d = 1'b0;
                end
                state_d = SHIFT;
            end
            SHIFT: begin
                // The adder carry-out becomes the new MSB, so no product bit is lost.
                prod_d  = {carry_q, prod_q[2*WIDTH-1:1]};
                carry_d = 1'b0;
                if (count_q == LAST) begin
`ifdef MULT_SIGNED_EN
                    state_d = FIX;
`else
                    state_d = DONE;
`endif
                end else begin
                    count_d = count_q + CNT_W'(1);
                    state_d = ADD;
                end
            end
`ifdef MULT_SIGNED_EN
            FIX: begin
                prod_d  = sign_q ? (~prod_q + (2*WIDTH)'(1)) : prod_q;
                state_d = DONE;
            end
`endif
            default: state_d = IDLE;
        endcase

        busy_d  = (state_d == ADD) || (state_d == SHIFT) || (state_d == FIX);
        ready_d = (state_d == DONE);
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            mcand_q <= '0;
            prod_q  <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
`ifdef MULT_SIGNED_EN
            sign_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            carry_q <= carry_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
`ifdef MULT_SIGNED_EN
            sign_q  <= sign_d;
`endif
        end
    end

    assign bus.Product_out = prod_q;
    assign bus.busy        = busy_q;
    assign bus.ready       = ready_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier with a product scoreboard; honours MULT_SIGNED_EN.
module tb_shift_add_multiplier;
    localparam int W = 32;
`ifdef MULT_SIGNED_EN
    localparam int LAT = 2*W + 1;
`else
    localparam int LAT = 2*W;
`endif

    typedef logic [2*W-1:0] word_t;

    logic clk = 1'b1;
    logic rst;

    shift_add_multiplier_if #(.WIDTH(W)) mif();

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (mif.slave)
    );

    always #5 clk = ~clk;

    int    errors = 0;
    int    checks = 0;
    word_t exp_q[$];

    logic [W-1:0] va [6] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h0000_0001, 32'hDEAD_BEEF, 32'h7FFF_FFFF, 32'h0000_FFFF};
    logic [W-1:0] vb [6] = '{32'h0000_0007, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1234_5678, 32'h7FFF_FFFF, 32'hFFFF_0001};

    task automatic check(input string tag, input word_t obs, input word_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic word_t model(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULT_SIGNED_EN
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return word_t'(sa * sb);
`else
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
`endif
    endfunction

    // Drives start for one falling edge; returns just after the accepting edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        @(posedge clk);
        mif.start           = 1'b1;
        mif.Multiplicand_in = a;
        mif.Multiplier_in   = b;
        if (push) exp_q.push_back(model(a, b));
        @(posedge clk);
        mif.start           = 1'b0;
        mif.Multiplicand_in = $urandom;
        mif.Multiplier_in   = $urandom;
        check("busy_after_accept", word_t'(mif.busy), word_t'(1));
    endtask

    // Waits (bounded) for ready; optionally pulses a start that must be ignored.
    task automatic wait_done(input int pulse_edge, input string tag);
        int e;
        e = 0;
        for (int i = 1; i <= LAT + 8; i++) begin
            @(posedge clk);
            if (mif.ready) begin
                e = i;
                break;
            end
            if (i == pulse_edge - 1) begin
                mif.start           = 1'b1;
                mif.Multiplicand_in = 32'd7;
                mif.Multiplier_in   = 32'd7;
            end
            if (i == pulse_edge) mif.start = 1'b0;
        end
        check({tag, "_latency"}, word_t'(e), word_t'(LAT));
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end else begin
            check({tag, "_product"}, mif.Product_out, exp_q.pop_front());
        end
        check({tag, "_busy_done"}, word_t'(mif.busy), word_t'(0));
    endtask

    initial begin
        rst                 = 1'b0;
        mif.start           = 1'b0;
        mif.Multiplicand_in = '0;
        mif.Multiplier_in   = '0;
        repeat (2) @(posedge clk);
        check("reset_product", mif.Product_out, word_t'(0));
        check("reset_busy", word_t'(mif.busy), word_t'(0));
        check("reset_ready", word_t'(mif.ready), word_t'(0));

        @(posedge clk);
        rst = 1'b1;

        start_op(32'd3, 32'd5, 1'b0);
        repeat (10) @(posedge clk);
        check("busy_mid_op", word_t'(mif.busy), word_t'(1));
        rst = 1'b0;
        #1;
        check("async_reset_product", mif.Product_out, word_t'(0));
        check("async_reset_busy", word_t'(mif.busy), word_t'(0));
        check("async_reset_ready", word_t'(mif.ready), word_t'(0));
        @(posedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        check("idle_after_reset_ready", word_t'(mif.ready), word_t'(0));
        check("idle_after_reset_busy", word_t'(mif.busy), word_t'(0));

        start_op(32'd3, 32'd5, 1'b1);
        wait_done(0, "small");
        repeat (4) @(posedge clk);
        check("done_hold_ready", word_t'(mif.ready), word_t'(1));
        check("done_hold_product", mif.Product_out, model(32'd3, 32'd5));

        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done(0, "max");

        start_op(32'd0, 32'h1234_5678, 1'b1);
        wait_done(20, "zero_ignored_start");

        start_op(32'h0001_0000, 32'h0001_0000, 1'b1);
        check("restart_ready_drop", word_t'(mif.ready), word_t'(0));
        wait_done(0, "back_to_back");

        for (int k = 0; k < 6; k++) begin
            start_op(va[k], vb[k], 1'b1);
            wait_done(0, $sformatf("vec%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
